// File: rtl/tt_mask_iter.sv
// tt_mask_iter: enumerates the set bits of a mask, one beat per set bit,
// lowest index first.
//
// Parameters
//   WIDTH : number of mask bits (power of two, >= 2)
//   SIZE  : index width, $clog2(WIDTH)
//
// Ports
//   i_clk     : clock, all state updates on the rising edge
//   i_reset   : asynchronous active-high reset
//   in_valid  : in_mask is valid
//   in_ready  : block can accept a mask this cycle (IDLE)
//   in_mask   : mask to enumerate, bit i = element i
//   out_valid : out_* beat is valid (BUSY)
//   out_ready : consumer accepts the beat
//   out_idx   : index of the current (lowest remaining) set bit
//   out_cnt   : number of set bits below out_idx in the captured mask
//   out_last  : current beat is the final set bit
//   o_done    : one-cycle pulse after a mask has been fully enumerated
//   o_total   : popcount of the most recently accepted mask
module tt_mask_iter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_idx,
    output logic [SIZE:0]    out_cnt,
    output logic             out_last,
    output logic             o_done,
    output logic [SIZE:0]    o_total
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] REM_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SIZE:0]    CNT_ONE = {{SIZE{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [SIZE:0]    cnt_q, cnt_d;
    logic [SIZE:0]    total_q, total_d;
    logic             done_q, done_d;

    logic [SIZE-1:0]  low_idx;
    logic [SIZE:0]    in_pop;
    logic             rem_single;
    logic             busy;

    assign busy = (state_q == BUSY);

    // Lowest set bit of the remaining mask. Scanning from the top down lets
    // the last match win, which is the lowest index.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (rem_q[WIDTH-1-i]) begin
                low_idx = SIZE'(WIDTH-1-i);
            end
        end
    end

    // Popcount of the incoming mask; SIZE+1 bits so all-ones gives WIDTH.
    always_comb begin
        in_pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            in_pop = in_pop + {{SIZE{1'b0}}, in_mask[i]};
        end
    end

    // Exactly one bit left: nonzero and clearing the lowest bit leaves zero.
    assign rem_single = (rem_q != '0) && ((rem_q & (rem_q - REM_ONE)) == '0);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = in_mask;
                    cnt_d   = '0;
                    total_d = in_pop;
                    if (in_mask == '0) begin
                        // Nothing to emit: finish without leaving IDLE.
                        done_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (out_ready) begin
                    rem_d = rem_q & (rem_q - REM_ONE);
                    cnt_d = cnt_q + CNT_ONE;
                    if (rem_single) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = ~busy;
    assign out_valid = busy;
    assign out_idx   = busy ? low_idx : '0;
    assign out_cnt   = busy ? cnt_q : '0;
    assign out_last  = busy & rem_single;
    assign o_done    = done_q;
    assign o_total   = total_q;

endmodule

// File: tb/tb_tt_mask_iter.sv
module tb_tt_mask_iter;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_mask = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_idx;
    logic [3:0] out_cnt;
    logic       out_last;
    logic       o_done;
    logic [3:0] o_total;

    int checks = 0;
    int passed = 0;

    always #5 i_clk = ~i_clk;

    tt_mask_iter #(.WIDTH(8)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mask  (in_mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_cnt  (out_cnt),
        .out_last (out_last),
        .o_done   (o_done),
        .o_total  (o_total)
    );

    // Every task starts and ends 1 time unit after a rising edge.

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_idx !== 3'd0) $display("FAIL reset_out_idx: got %0d expected 0", out_idx); else passed++;
        checks++; if (out_cnt !== 4'd0) $display("FAIL reset_out_cnt: got %0d expected 0", out_cnt); else passed++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last); else passed++;
        checks++; if (o_done !== 1'b0) $display("FAIL reset_o_done: got %b expected 0", o_done); else passed++;
        checks++; if (o_total !== 4'd0) $display("FAIL reset_o_total: got %0d expected 0", o_total); else passed++;
        i_reset = 1'b0;
    endtask

    task automatic test_a5();
        int exp_idx [4];
        exp_idx = '{0, 2, 5, 7};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 8'hA5;
        @(posedge i_clk); #1;
        in_valid = 1'b0;
        checks++; if (o_total !== 4'd4) $display("FAIL a5_total: got %0d expected 4", o_total); else passed++;
        for (int b = 0; b < 4; b++) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL a5_valid beat %0d: got %b expected 1", b, out_valid); else passed++;
            checks++; if (out_idx !== 3'(exp_idx[b])) $display("FAIL a5_idx beat %0d: got %0d expected %0d", b, out_idx, exp_idx[b]); else passed++;
            checks++; if (out_cnt !== 4'(b)) $display("FAIL a5_cnt beat %0d: got %0d expected %0d", b, out_cnt, b); else passed++;
            checks++; if (out_last !== (b == 3)) $display("FAIL a5_last beat %0d: got %b expected %b", b, out_last, (b == 3)); else passed++;
            checks++; if (o_done !== 1'b0) $display("FAIL a5_early_done beat %0d: got %b expected 0", b, o_done); else passed++;
            @(posedge i_clk); #1;
        end
        checks++; if (o_done !== 1'b1) $display("FAIL a5_done: got %b expected 1", o_done); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL a5_valid_after: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL a5_ready_after: got %b expected 1", in_ready); else passed++;
        @(posedge i_clk); #1;
        checks++; if (o_done !== 1'b0) $display("FAIL a5_done_pulse: got %b expected 0", o_done); else passed++;
        checks++; if (o_total !== 4'd4) $display("FAIL a5_total_held: got %0d expected 4", o_total); else passed++;
    endtask

    task automatic test_zero();
        in_valid = 1'b1;
        in_mask  = 8'h00;
        checks++; if (in_ready !== 1'b1) $display("FAIL zero_ready_before: got %b expected 1", in_ready); else passed++;
        @(posedge i_clk); #1;
        in_valid = 1'b0;
        checks++; if (o_done !== 1'b1) $display("FAIL zero_done: got %b expected 1", o_done); else passed++;
        checks++; if (o_total !== 4'd0) $display("FAIL zero_total: got %0d expected 0", o_total); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL zero_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL zero_ready: got %b expected 1", in_ready); else passed++;
        @(posedge i_clk); #1;
        checks++; if (o_done !== 1'b0) $display("FAIL zero_done_pulse: got %b expected 0", o_done); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL zero_valid_later: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_ff();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 8'hFF;
        @(posedge i_clk); #1;
        in_valid = 1'b0;
        checks++; if (o_total !== 4'd8) $display("FAIL ff_total: got %0d expected 8", o_total); else passed++;
        for (int b = 0; b < 8; b++) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL ff_valid beat %0d: got %b expected 1", b, out_valid); else passed++;
            checks++; if (out_idx !== 3'(b)) $display("FAIL ff_idx beat %0d: got %0d expected %0d", b, out_idx, b); else passed++;
            checks++; if (out_cnt !== 4'(b)) $display("FAIL ff_cnt beat %0d: got %0d expected %0d", b, out_cnt, b); else passed++;
            checks++; if (out_last !== (b == 7)) $display("FAIL ff_last beat %0d: got %b expected %b", b, out_last, (b == 7)); else passed++;
            @(posedge i_clk); #1;
        end
        checks++; if (o_done !== 1'b1) $display("FAIL ff_done: got %b expected 1", o_done); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL ff_valid_after: got %b expected 0", out_valid); else passed++;
        @(posedge i_clk); #1;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mask   = 8'h90;
        @(posedge i_clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid cyc %0d: got %b expected 1", c, out_valid); else passed++;
            checks++; if (out_idx !== 3'd4) $display("FAIL stall_idx cyc %0d: got %0d expected 4", c, out_idx); else passed++;
            checks++; if (out_cnt !== 4'd0) $display("FAIL stall_cnt cyc %0d: got %0d expected 0", c, out_cnt); else passed++;
            checks++; if (out_last !== 1'b0) $display("FAIL stall_last cyc %0d: got %b expected 0", c, out_last); else passed++;
            @(posedge i_clk); #1;
        end
        out_ready = 1'b1;
        checks++; if (out_idx !== 3'd4) $display("FAIL stall_idx_release: got %0d expected 4", out_idx); else passed++;
        @(posedge i_clk); #1;
        checks++; if (out_idx !== 3'd7) $display("FAIL stall_idx2: got %0d expected 7", out_idx); else passed++;
        checks++; if (out_cnt !== 4'd1) $display("FAIL stall_cnt2: got %0d expected 1", out_cnt); else passed++;
        checks++; if (out_last !== 1'b1) $display("FAIL stall_last2: got %b expected 1", out_last); else passed++;
        @(posedge i_clk); #1;
        checks++; if (o_done !== 1'b1) $display("FAIL stall_done: got %b expected 1", o_done); else passed++;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 8'h0F;
        @(posedge i_clk); #1;
        in_valid = 1'b0;
        checks++; if (out_idx !== 3'd0) $display("FAIL rmid_idx0: got %0d expected 0", out_idx); else passed++;
        @(posedge i_clk); #1;
        checks++; if (out_idx !== 3'd1) $display("FAIL rmid_idx1: got %0d expected 1", out_idx); else passed++;
        @(posedge i_clk); #1;
        checks++; if (out_idx !== 3'd2) $display("FAIL rmid_idx2: got %0d expected 2", out_idx); else passed++;
        i_reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid_async: got %b expected 0", out_valid); else passed++;
        checks++; if (out_idx !== 3'd0) $display("FAIL rmid_idx_reset: got %0d expected 0", out_idx); else passed++;
        checks++; if (o_total !== 4'd0) $display("FAIL rmid_total_reset: got %0d expected 0", o_total); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rmid_ready_reset: got %b expected 1", in_ready); else passed++;
        @(posedge i_clk); #1;
        checks++; if (o_done !== 1'b0) $display("FAIL rmid_done_in_reset: got %b expected 0", o_done); else passed++;
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        checks++; if (o_done !== 1'b0) $display("FAIL rmid_done_after: got %b expected 0", o_done); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid_after: got %b expected 0", out_valid); else passed++;
        in_valid = 1'b1;
        in_mask  = 8'h01;
        @(posedge i_clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL rmid_new_valid: got %b expected 1", out_valid); else passed++;
        checks++; if (out_idx !== 3'd0) $display("FAIL rmid_new_idx: got %0d expected 0", out_idx); else passed++;
        checks++; if (out_cnt !== 4'd0) $display("FAIL rmid_new_cnt: got %0d expected 0", out_cnt); else passed++;
        checks++; if (out_last !== 1'b1) $display("FAIL rmid_new_last: got %b expected 1", out_last); else passed++;
        checks++; if (o_total !== 4'd1) $display("FAIL rmid_new_total: got %0d expected 1", o_total); else passed++;
        @(posedge i_clk); #1;
        checks++; if (o_done !== 1'b1) $display("FAIL rmid_new_done: got %b expected 1", o_done); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rmid_new_end: got %b expected 0", out_valid); else passed++;
        @(posedge i_clk); #1;
    endtask

    task automatic test_back_to_back();
        int exp_idx [4];
        exp_idx = '{0, 1, 4, 5};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mask   = 8'h33;
        @(posedge i_clk); #1;
        in_mask = 8'h01;
        for (int b = 0; b < 4; b++) begin
            checks++; if (in_ready !== 1'b0) $display("FAIL b2b_ready beat %0d: got %b expected 0", b, in_ready); else passed++;
            checks++; if (out_idx !== 3'(exp_idx[b])) $display("FAIL b2b_idx beat %0d: got %0d expected %0d", b, out_idx, exp_idx[b]); else passed++;
            checks++; if (out_cnt !== 4'(b)) $display("FAIL b2b_cnt beat %0d: got %0d expected %0d", b, out_cnt, b); else passed++;
            checks++; if (o_total !== 4'd4) $display("FAIL b2b_total beat %0d: got %0d expected 4", b, o_total); else passed++;
            @(posedge i_clk); #1;
        end
        checks++; if (o_done !== 1'b1) $display("FAIL b2b_done: got %b expected 1", o_done); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_idle: got %b expected 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_bubble: got %b expected 0", out_valid); else passed++;
        checks++; if (o_total !== 4'd4) $display("FAIL b2b_total_bubble: got %0d expected 4", o_total); else passed++;
        @(posedge i_clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b_second_valid: got %b expected 1", out_valid); else passed++;
        checks++; if (out_idx !== 3'd0) $display("FAIL b2b_second_idx: got %0d expected 0", out_idx); else passed++;
        checks++; if (out_last !== 1'b1) $display("FAIL b2b_second_last: got %b expected 1", out_last); else passed++;
        checks++; if (o_total !== 4'd1) $display("FAIL b2b_second_total: got %0d expected 1", o_total); else passed++;
        @(posedge i_clk); #1;
        checks++; if (o_done !== 1'b1) $display("FAIL b2b_second_done: got %b expected 1", o_done); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_second_end: got %b expected 0", out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_a5();
        test_zero();
        test_ff();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tt_mask_iter.md
TT_MASK_ITER -- requirements
Module: tt_mask_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of mask bits; a power of two and at least 2.
REQ-002 SHALL have parameter SIZE, default $clog2(WIDTH), the index width.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_mask is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a mask this cycle.
REQ-007 SHALL have port in_mask, input, WIDTH bits: the mask to enumerate; bit i = element i.
REQ-008 SHALL have port out_valid, output, 1 bit: the out_* beat is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-010 SHALL have port out_idx, output, SIZE bits: index of the current set bit.
REQ-011 SHALL have port out_cnt, output, SIZE+1 bits: number of set bits in the captured mask below out_idx (iota value).
REQ-012 SHALL have port out_last, output, 1 bit: the current beat is the final set bit of the mask.
REQ-013 SHALL have port o_done, output, 1 bit: one-cycle pulse when enumeration of a mask completes.
REQ-014 SHALL have port o_total, output, SIZE+1 bits: popcount of the most recently accepted mask, held until the next acceptance.

Function
REQ-015 SHALL implement two states: IDLE, with in_ready=1 and out_valid=0, and BUSY, with in_ready=0 and out_valid=1.
REQ-016 SHALL, in IDLE with in_valid=1, accept the mask: capture it into a remaining-mask register, clear the running count, and load o_total with the popcount (0..WIDTH inclusive).
REQ-017 SHALL, on accepting a nonzero mask, enter BUSY, with out_valid first asserted the cycle after acceptance.
REQ-018 SHALL, on accepting an all-zero mask, stay in IDLE, emit no beats, and pulse o_done the cycle after acceptance with o_total=0.
REQ-019 SHALL, in BUSY, drive out_idx as the lowest set bit of the remaining mask (LSB-first order).
REQ-020 SHALL, in BUSY, drive out_cnt as the running count and out_last=1 exactly when the remaining mask has one set bit.
REQ-021 SHALL hold out_valid, out_idx, out_cnt and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on a handshake (out_valid and out_ready), clear the emitted bit in the remaining mask and increment the running count by 1.
REQ-023 SHALL, on the handshake of the out_last beat, return to IDLE and pulse o_done in the following cycle.
REQ-024 SHALL ignore in_valid while BUSY and leave in_mask uncaptured.
REQ-025 SHALL accept a new mask no earlier than the cycle after the final handshake, giving a minimum one-cycle bubble between masks.
REQ-026 SHALL drive exactly popcount(mask) beats per nonzero mask, with strictly increasing out_idx and out_cnt running 0..total-1.
REQ-027 SHALL compute the lowest-set-bit select and the popcount combinationally within one cycle for any WIDTH.
REQ-028 SHALL keep out_cnt and o_total wide enough for WIDTH, so that an all-ones mask gives o_total=WIDTH without overflow.

Reset
REQ-029 SHALL, while i_reset=1, force IDLE with in_ready=1, out_valid=0, out_idx=0, out_cnt=0, out_last=0, o_done=0, o_total=0, and the remaining mask cleared.
REQ-030 SHALL, on reset asserted mid-enumeration, abandon the mask immediately with no further beats and no o_done pulse.
REQ-031 SHALL accept in_valid from the first rising edge after i_reset deasserts.

Verification
REQ-032 SHALL cover: WIDTH=8, in_mask=0xA5, out_ready=1 -> 4 beats (idx,cnt) = (0,0), (2,1), (5,2), (7,3), out_last only on idx 7, o_total=4, o_done one cycle after the last beat.
REQ-033 SHALL cover: in_mask=0x00 -> no out_valid, o_done pulse the next cycle, o_total=0, in_ready stays 1.
REQ-034 SHALL cover: in_mask=0xFF -> 8 beats idx 0..7, cnt 0..7, o_total=8.
REQ-035 SHALL cover: in_mask=0x90 with out_ready low for 3 cycles -> idx=4, cnt=0 held stable for 3 cycles, then idx=7 with out_last=1.
REQ-036 SHALL cover: in_mask=0x0F, i_reset asserted after the 2nd beat -> out_valid=0 at once, no o_done, and a following mask 0x01 gives a single beat idx=0, cnt=0, out_last=1.
REQ-037 SHALL cover: in_valid held high with 0x33 then 0x01 while BUSY -> 0x01 not captured until IDLE, with in_ready=0 throughout BUSY.
